// File: rtl/uart_transmitter.sv
// uart_transmitter
//
// Serial transmit stage of the UART channel. A byte written with a one-cycle
// Tx_WR strobe is sent on TxD as an 11-bit frame:
//   start (0), 8 data bits LSB first, even parity, stop (1).
// Each bit lasts TICKS_PER_BIT sample ticks. A 14-bit baud down-counter
// produces the ticks, using the same rate codes as uart_receiver.
//
// Ports
//   clk          system clock (50 MHz)
//   reset        asynchronous, active-high
//   baud_select  rate code, latched at frame start:
//                000=300 001=1200 010=4800 011=9600
//                100=19200 101=38400 110=57600 111=115200
//   Tx_EN        transmitter enable; low forces idle and aborts any frame
//   Tx_WR        one-cycle write strobe for Tx_DATA
//   Tx_DATA      byte to send
//   TxD          serial line, idles high (registered)
//   Tx_BUSY      high when a write would be refused (registered)
//
// Optional feature: define UART_TX_HOLD_EN to add a one-entry holding
// register. With it, Tx_BUSY means "holding register full". A byte written
// during a frame is sent back-to-back with no idle gap.

module uart_transmitter #(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY
);

  localparam int DATA_W = 8;
  localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Baud-counter reload per rate code. The counter runs reload-1 down to 0,
  // so one sample tick occurs every 'reload' clocks.
  function automatic logic [13:0] baud_reload(input logic [2:0] code);
    logic [13:0] rl;
    case (code)
      3'b000:  rl = 14'd10417;
      3'b001:  rl = 14'd2604;
      3'b010:  rl = 14'd651;
      3'b011:  rl = 14'd326;
      3'b100:  rl = 14'd163;
      3'b101:  rl = 14'd81;
      3'b110:  rl = 14'd54;
      default: rl = 14'd27;
    endcase
    return rl;
  endfunction

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Registered state
  state_t              r_state;
  logic [13:0]         r_baud_cnt;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [2:0]          r_bit_idx;
  logic [2:0]          r_baud;
  logic [DATA_W-1:0]   r_shift;
  logic                r_parity;
  logic                r_txd;
  logic                r_busy;
`ifdef UART_TX_HOLD_EN
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;
`endif

  // Next-state values
  state_t              w_state_nxt;
  logic [13:0]         w_baud_cnt_nxt;
  logic [TICK_W-1:0]   w_tick_cnt_nxt;
  logic [2:0]          w_bit_idx_nxt;
  logic [2:0]          w_baud_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_parity_nxt;
  logic                w_txd_nxt;
  logic                w_busy_nxt;
  logic                w_wr_ok;
  logic                w_bit_end;
  logic                w_start;
  logic [DATA_W-1:0]   w_start_data;
`ifdef UART_TX_HOLD_EN
  logic [DATA_W-1:0]   w_hold_nxt;
  logic                w_hold_full_nxt;
`endif

  assign w_wr_ok = Tx_WR & Tx_EN & ~r_busy;

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt;
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_baud_nxt     = r_baud;
    w_shift_nxt    = r_shift;
    w_parity_nxt   = r_parity;
    w_bit_end      = 1'b0;
    w_start        = 1'b0;
    w_start_data   = Tx_DATA;
`ifdef UART_TX_HOLD_EN
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
`endif

    if (!Tx_EN) begin
      // Disable aborts everything: idle line, pending byte dropped, and the
      // baud counter parked at its reload value.
      w_state_nxt    = S_IDLE;
      w_baud_cnt_nxt = baud_reload(r_baud) - 14'd1;
      w_tick_cnt_nxt = '0;
      w_bit_idx_nxt  = '0;
`ifdef UART_TX_HOLD_EN
      w_hold_full_nxt = 1'b0;
`endif
    end else begin
      if (r_state != S_IDLE) begin
        if (r_baud_cnt == 14'd0) begin
          w_baud_cnt_nxt = baud_reload(r_baud) - 14'd1;
          w_bit_end      = (r_tick_cnt == TICK_LAST);
          w_tick_cnt_nxt = w_bit_end ? '0 : r_tick_cnt + TICK_W'(1);
        end else begin
          w_baud_cnt_nxt = r_baud_cnt - 14'd1;
        end
      end

      if (w_bit_end) begin
        case (r_state)
          S_START: begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = '0;
          end
          S_DATA: begin
            w_shift_nxt = r_shift >> 1;
            if (r_bit_idx == 3'd7) begin
              w_state_nxt = S_PARITY;
            end else begin
              w_bit_idx_nxt = r_bit_idx + 3'd1;
            end
          end
          S_PARITY: w_state_nxt = S_STOP;
          S_STOP:   w_state_nxt = S_IDLE;
          default:  w_state_nxt = S_IDLE;
        endcase
      end

`ifdef UART_TX_HOLD_EN
      // A held byte takes over at the end of STOP. A write that arrives
      // exactly then, with nothing held, starts directly. Otherwise a write
      // during a frame is parked in the holding register.
      if (w_bit_end && (r_state == S_STOP) && r_hold_full) begin
        w_start         = 1'b1;
        w_start_data    = r_hold;
        w_hold_full_nxt = 1'b0;
      end else if (w_wr_ok) begin
        if ((r_state == S_IDLE) || (w_bit_end && (r_state == S_STOP))) begin
          w_start = 1'b1;
        end else begin
          w_hold_nxt      = Tx_DATA;
          w_hold_full_nxt = 1'b1;
        end
      end
`else
      // Tx_BUSY mirrors "not idle", so an accepted write always starts here.
      if (w_wr_ok) begin
        w_start = 1'b1;
      end
`endif

      if (w_start) begin
        // Restart the baud counter so the start bit is full length.
        w_state_nxt    = S_START;
        w_shift_nxt    = w_start_data;
        w_parity_nxt   = even_parity(w_start_data);
        w_baud_nxt     = baud_select;
        w_baud_cnt_nxt = baud_reload(baud_select) - 14'd1;
        w_tick_cnt_nxt = '0;
        w_bit_idx_nxt  = '0;
      end
    end

`ifdef UART_TX_HOLD_EN
    w_busy_nxt = w_hold_full_nxt;
`else
    w_busy_nxt = (w_state_nxt != S_IDLE);
`endif

    // TxD is computed from the next state, so the line changes on the same
    // edge as the FSM without a combinational path to the pin.
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shift_nxt[0];
      S_PARITY: w_txd_nxt = w_parity_nxt;
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_baud      <= '0;
      r_txd       <= 1'b1;
      r_busy      <= 1'b0;
`ifdef UART_TX_HOLD_EN
      r_hold_full <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_baud_cnt  <= w_baud_cnt_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_baud      <= w_baud_nxt;
      r_txd       <= w_txd_nxt;
      r_busy      <= w_busy_nxt;
`ifdef UART_TX_HOLD_EN
      r_hold_full <= w_hold_full_nxt;
`endif
    end
  end

  // Data registers; these are only observed while the FSM or the hold flag
  // says they are valid.
  always_ff @(posedge clk) begin
    r_shift  <= w_shift_nxt;
    r_parity <= w_parity_nxt;
`ifdef UART_TX_HOLD_EN
    r_hold   <= w_hold_nxt;
`endif
  end

  assign TxD     = r_txd;
  assign Tx_BUSY = r_busy;

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage of the UART channel: it accepts a byte over a one-cycle write strobe and serialises it onto TxD as an 11-bit frame. The frame is start bit, 8 data bits LSB first, even parity, and stop bit. It is the direct upstream partner of uart_receiver: TxD drives the receiver's RxD, and both ends use the same baud_select encoding and 16x sample-tick scheme.

## Interface
- TICKS_PER_BIT, 16: sample ticks per serial bit; must match the receiver.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- baud_select  in  3  rate code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
- Tx_EN  in  1  transmitter enable; low holds the block idle.
- Tx_WR  in  1  one-cycle write strobe for Tx_DATA.
- Tx_DATA  in  8  byte to send.
- TxD  out  1  serial line; idles high.
- Tx_BUSY  out  1  high when a write would be refused.

## Operation
- Baud generator: a 14-bit down-counter emits a one-cycle sample tick.
  - Reload values by code 000..111: 10417, 2604, 651, 326, 163, 81, 54, 27.
  - Counter is reloaded at frame start, so the first bit is full length.
  - Held at reload while Tx_EN=0.
- baud_select is latched at frame start; changes mid-frame take effect on the next frame.
- Frame start also latches Tx_DATA into the shift register and computes parity = XOR of the 8 data bits.
- FSM states and transitions:
  - IDLE: TxD=1.
  - START: TxD=0.
  - DATA: TxD=shift[0]; shift right per bit; 3-bit index goes 0..7.
  - PARITY: TxD=parity.
  - STOP: TxD=1.
  - Each non-IDLE state lasts TICKS_PER_BIT ticks.
  - After STOP, the FSM goes to IDLE, or straight to START if a byte is pending (see Configuration).
- Write acceptance: Tx_WR with Tx_EN=1 and Tx_BUSY=0 is accepted. Every other Tx_WR is dropped silently.
- Tx_EN falling while in any state:
  - FSM to IDLE next cycle; TxD=1; Tx_BUSY=0.
  - Pending byte discarded; frame aborted.
- Tx_WR and Tx_EN falling in the same cycle: write dropped.
- Reset (async, any time): FSM=IDLE, TxD=1, Tx_BUSY=0, counters 0, holding register empty.

## Timing
- Accepted write at edge N:
  - Tx_BUSY=1 and TxD=0 (START) from edge N+1.
  - No bubble.
- Bit period = 16 × reload cycles, e.g. 432 cycles (8640 ns) at code 111.
- Frame = 11 bits = 4752 cycles at code 111.
- Without UART_TX_HOLD_EN:
  - Tx_BUSY stays high through STOP.
  - Tx_BUSY drops on the cycle TxD enters IDLE.
  - A new write is accepted that same cycle at the earliest.
- Outputs are registered; no combinational path from inputs to TxD or Tx_BUSY.

## Configuration
- UART_TX_HOLD_EN defined: a one-entry holding register is added.
  - Tx_BUSY = holding register full.
  - A write during a frame fills the holding register.
  - At STOP end the pending byte moves into the shifter and START begins the next cycle: back-to-back frames with zero idle gap.
  - Tx_BUSY clears in the cycle of that transfer.
  - A write in IDLE with the register empty bypasses the register, as in the baseline.
- UART_TX_HOLD_EN undefined: no holding register; behaviour as described in Timing.

## Test plan
- Single byte:
  - Stimulus: reset 100 ns, Tx_EN=1, baud 111, write 0x4D.
  - Required TxD: 0,1,0,1,1,0,0,1,0,0,1, each bit 432 cycles.
  - Required Tx_BUSY: high for 4752 cycles.
- Loopback into uart_receiver at baud 111:
  - Stimulus: send 0x4D, then 0xFF.
  - Required: Rx_VALID pulses with Rx_DATA=0x4D, then 0xFF; Rx_PERROR=0 and Rx_FERROR=0 both times.
  - Parity bit for 0xFF is 0.
- Baud rate:
  - Stimulus: baud 011, send 0x01; switch baud_select to 111 mid-frame.
  - Required: every bit is 5216 cycles; parity bit=1.
  - Required: next frame uses 432 cycles per bit.
- Refused writes:
  - Stimulus: Tx_WR while Tx_BUSY=1 (0x55); Tx_WR with Tx_EN=0 (0xAA).
  - Required: both ignored, TxD unchanged, no extra frame.
- Abort:
  - Stimulus: drop Tx_EN during DATA bit 3; assert reset mid-frame on a second run.
  - Required: TxD=1 and Tx_BUSY=0 within one cycle (reset: immediately).
  - Required: the next write after re-enable produces a full, correct frame.
- Holding register (UART_TX_HOLD_EN):
  - Stimulus: write 0x4D, then 0xA5 during the 0x4D frame.
  - Required: 0xA5 START begins the cycle after 0x4D STOP ends.
  - Required: a third write is refused while Tx_BUSY=1.
